// File: rtl/lnrv_exu_lsu_ots_pkg.sv
// rtl/lnrv_exu_lsu_ots_pkg.sv - LSU size encodings and lane/alignment helpers
package lnrv_exu_lsu_ots_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
    localparam logic [1:0] LSU_SIZE_WORD = 2'd2;

    // Metadata is {load, store, size[1:0], uext, rd_idx, addr[31:0]}
    function automatic int lsu_meta_width(input int rd_w);
        return 2 + 2 + 1 + rd_w + 32;
    endfunction

    // Size 3 never aligns, so it always takes the misaligned path
    function automatic logic lsu_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            LSU_SIZE_BYTE: ok = 1'b1;
            LSU_SIZE_HALF: ok = ~lo[0];
            LSU_SIZE_WORD: ok = (lo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lsu_wstrb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            LSU_SIZE_BYTE: s = 4'b0001 << lo;
            LSU_SIZE_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
            default:       s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicating the data makes it land on whichever lane the strobes select
    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] d;
        case (size)
            LSU_SIZE_BYTE: d = {4{rs2[7:0]}};
            LSU_SIZE_HALF: d = {2{rs2[15:0]}};
            default:       d = rs2;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] lsu_ld_extend(input logic [1:0]  size,
                                                  input logic        uext,
                                                  input logic [1:0]  lo,
                                                  input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LSU_SIZE_BYTE: r = uext ? {24'd0, b} : {{24{b[7]}}, b};
            LSU_SIZE_HALF: r = uext ? {16'd0, h} : {{16{h[15]}}, h};
            default:       r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lnrv_lsu_meta_fifo.sv
// rtl/lnrv_lsu_meta_fifo.sv - synchronous metadata FIFO for outstanding LSU transactions
module lnrv_lsu_meta_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage; contents need no reset since count gates their use
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lnrv_exu_lsu_ots.sv
// rtl/lnrv_exu_lsu_ots.sv - load/store unit with registered command stage and outstanding FIFO
module lnrv_exu_lsu_ots
    import lnrv_exu_lsu_ots_pkg::*;
#(
    parameter  int OTS_DEPTH = 2,
    parameter  int RD_W      = 5,
    localparam int CNT_W     = $clog2(OTS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_vld,
    output logic             op_rdy,
    input  logic             op_load,
    input  logic             op_store,
    input  logic [1:0]       op_size,
    input  logic             op_uext,
    input  logic [RD_W-1:0]  op_rd_idx,
    input  logic [31:0]      rs1_rdata,
    input  logic [31:0]      rs2_rdata,
    input  logic [31:0]      imm,
    output logic             lsu_cmd_vld,
    input  logic             lsu_cmd_rdy,
    output logic             lsu_cmd_write,
    output logic [31:0]      lsu_cmd_addr,
    output logic [31:0]      lsu_cmd_wdata,
    output logic [3:0]       lsu_cmd_wstrb,
    input  logic             lsu_rsp_vld,
    output logic             lsu_rsp_rdy,
    input  logic [31:0]      lsu_rsp_rdata,
    input  logic             lsu_rsp_err,
    output logic             gpr_wbck_vld,
    input  logic             gpr_wbck_rdy,
    output logic [RD_W-1:0]  gpr_wbck_idx,
    output logic [31:0]      gpr_wbck_wdata,
    output logic             lsu_excp_vld,
    input  logic             lsu_excp_rdy,
    output logic             lsu_ld_addr_misalgn,
    output logic             lsu_st_addr_misalgn,
    output logic             lsu_ld_access_fault,
    output logic             lsu_st_access_fault,
    output logic [31:0]      lsu_bad_addr,
    output logic [CNT_W-1:0] ots_cnt
);

    localparam int META_W    = lsu_meta_width(RD_W);
    localparam int ADDR_LOC  = 0;
    localparam int RD_LOC    = 32;
    localparam int UEXT_LOC  = 32 + RD_W;
    localparam int SIZE_LOC  = 33 + RD_W;
    localparam int STORE_LOC = 35 + RD_W;
    localparam int LOAD_LOC  = 36 + RD_W;

    logic              cmd_vld_q;
    logic              cmd_write_q;
    logic [31:0]       cmd_addr_q;
    logic [31:0]       cmd_wdata_q;
    logic [3:0]        cmd_wstrb_q;

    logic [31:0]       addr;
    logic              aligned;
    logic              drained;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [META_W-1:0] push_meta;
    logic [META_W-1:0] head;
    logic              head_load;
    logic              head_store;
    logic [1:0]        head_size;
    logic              head_uext;
    logic [31:0]       head_addr;
    logic              rsp_excp;
    logic              mis_excp;

    assign addr    = rs1_rdata + imm;
    assign aligned = lsu_aligned(op_size, addr[1:0]);
    // A misaligned op only reports once everything older has fully retired
    assign drained = fifo_empty & ~cmd_vld_q;

    assign op_rdy = aligned ? ((~cmd_vld_q | lsu_cmd_rdy) & ~fifo_full)
                            : (drained & lsu_excp_rdy);
    assign push   = op_vld & op_rdy & aligned;

    assign push_meta = {op_load, op_store, op_size, op_uext, op_rd_idx, addr};

    assign head_addr  = head[ADDR_LOC +: 32];
    assign head_uext  = head[UEXT_LOC];
    assign head_size  = head[SIZE_LOC +: 2];
    assign head_store = head[STORE_LOC];
    assign head_load  = head[LOAD_LOC];

    // Command register stage; a reload in the handshake cycle keeps it valid
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_vld_q   <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
        end else if (push) begin
            cmd_vld_q   <= 1'b1;
            cmd_write_q <= op_store;
            cmd_addr_q  <= addr;
            cmd_wdata_q <= lsu_wdata(op_size, rs2_rdata);
            cmd_wstrb_q <= op_store ? lsu_wstrb(op_size, addr[1:0]) : 4'b0000;
        end else if (lsu_cmd_rdy) begin
            cmd_vld_q   <= 1'b0;
        end
    end

    assign lsu_cmd_vld   = cmd_vld_q;
    assign lsu_cmd_write = cmd_write_q;
    assign lsu_cmd_addr  = cmd_addr_q;
    assign lsu_cmd_wdata = cmd_wdata_q;
    assign lsu_cmd_wstrb = cmd_wstrb_q;

    lnrv_lsu_meta_fifo #(
        .DEPTH (OTS_DEPTH),
        .WIDTH (META_W)
    ) u_meta_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_meta),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (ots_cnt),
        .head      (head)
    );

    // The response is held until whichever consumer it targets can take it
    assign lsu_rsp_rdy = fifo_empty  ? 1'b0 :
                         lsu_rsp_err ? lsu_excp_rdy :
                         head_load   ? gpr_wbck_rdy : 1'b1;
    assign pop = lsu_rsp_vld & lsu_rsp_rdy;

    assign gpr_wbck_vld   = lsu_rsp_vld & ~lsu_rsp_err & head_load & ~fifo_empty;
    assign gpr_wbck_idx   = head[RD_LOC +: RD_W];
    assign gpr_wbck_wdata = lsu_ld_extend(head_size, head_uext, head_addr[1:0], lsu_rsp_rdata);

    assign rsp_excp = lsu_rsp_vld & lsu_rsp_err & ~fifo_empty;
    assign mis_excp = op_vld & ~aligned & drained;

    assign lsu_excp_vld        = rsp_excp | mis_excp;
    assign lsu_ld_access_fault = rsp_excp & head_load;
    assign lsu_st_access_fault = rsp_excp & head_store;
    assign lsu_ld_addr_misalgn = ~rsp_excp & mis_excp & op_load;
    assign lsu_st_addr_misalgn = ~rsp_excp & mis_excp & op_store;
    assign lsu_bad_addr        = rsp_excp ? head_addr : addr;

endmodule

// File: tb/tb_lnrv_exu_lsu_ots.sv
// tb/tb_lnrv_exu_lsu_ots.sv - directed self-checking bench for lnrv_exu_lsu_ots
module tb_lnrv_exu_lsu_ots;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_vld;
    logic        op_rdy;
    logic        op_load;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_uext;
    logic [4:0]  op_rd_idx;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] imm;
    logic        lsu_cmd_vld;
    logic        lsu_cmd_rdy;
    logic        lsu_cmd_write;
    logic [31:0] lsu_cmd_addr;
    logic [31:0] lsu_cmd_wdata;
    logic [3:0]  lsu_cmd_wstrb;
    logic        lsu_rsp_vld;
    logic        lsu_rsp_rdy;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic        gpr_wbck_vld;
    logic        gpr_wbck_rdy;
    logic [4:0]  gpr_wbck_idx;
    logic [31:0] gpr_wbck_wdata;
    logic        lsu_excp_vld;
    logic        lsu_excp_rdy;
    logic        lsu_ld_addr_misalgn;
    logic        lsu_st_addr_misalgn;
    logic        lsu_ld_access_fault;
    logic        lsu_st_access_fault;
    logic [31:0] lsu_bad_addr;
    logic [1:0]  ots_cnt;

    int nvec = 0;
    int nerr = 0;

    lnrv_exu_lsu_ots #(.OTS_DEPTH(2), .RD_W(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .op_vld              (op_vld),
        .op_rdy              (op_rdy),
        .op_load             (op_load),
        .op_store            (op_store),
        .op_size             (op_size),
        .op_uext             (op_uext),
        .op_rd_idx           (op_rd_idx),
        .rs1_rdata           (rs1_rdata),
        .rs2_rdata           (rs2_rdata),
        .imm                 (imm),
        .lsu_cmd_vld         (lsu_cmd_vld),
        .lsu_cmd_rdy         (lsu_cmd_rdy),
        .lsu_cmd_write       (lsu_cmd_write),
        .lsu_cmd_addr        (lsu_cmd_addr),
        .lsu_cmd_wdata       (lsu_cmd_wdata),
        .lsu_cmd_wstrb       (lsu_cmd_wstrb),
        .lsu_rsp_vld         (lsu_rsp_vld),
        .lsu_rsp_rdy         (lsu_rsp_rdy),
        .lsu_rsp_rdata       (lsu_rsp_rdata),
        .lsu_rsp_err         (lsu_rsp_err),
        .gpr_wbck_vld        (gpr_wbck_vld),
        .gpr_wbck_rdy        (gpr_wbck_rdy),
        .gpr_wbck_idx        (gpr_wbck_idx),
        .gpr_wbck_wdata      (gpr_wbck_wdata),
        .lsu_excp_vld        (lsu_excp_vld),
        .lsu_excp_rdy        (lsu_excp_rdy),
        .lsu_ld_addr_misalgn (lsu_ld_addr_misalgn),
        .lsu_st_addr_misalgn (lsu_st_addr_misalgn),
        .lsu_ld_access_fault (lsu_ld_access_fault),
        .lsu_st_access_fault (lsu_st_access_fault),
        .lsu_bad_addr        (lsu_bad_addr),
        .ots_cnt             (ots_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        op_vld = 0; op_load = 0; op_store = 0; op_size = 2'd2; op_uext = 0;
        op_rd_idx = 0; rs1_rdata = 0; rs2_rdata = 0; imm = 0;
        lsu_cmd_rdy = 1; lsu_rsp_vld = 0; lsu_rsp_rdata = 0; lsu_rsp_err = 0;
        gpr_wbck_rdy = 1; lsu_excp_rdy = 1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic ue,
                            input logic [4:0] rd, input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] data);
        op_vld = 1; op_load = ld; op_store = st; op_size = sz; op_uext = ue;
        op_rd_idx = rd; rs1_rdata = base; imm = off; rs2_rdata = data;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        settle();
        nvec++; if (lsu_cmd_vld !== 1'b0) begin nerr++; $display("FAIL rst_cmd_vld: got %0b want 0", lsu_cmd_vld); end
        nvec++; if (lsu_rsp_rdy !== 1'b0) begin nerr++; $display("FAIL rst_rsp_rdy: got %0b want 0", lsu_rsp_rdy); end
        nvec++; if (gpr_wbck_vld !== 1'b0) begin nerr++; $display("FAIL rst_wbck_vld: got %0b want 0", gpr_wbck_vld); end
        nvec++; if (lsu_excp_vld !== 1'b0) begin nerr++; $display("FAIL rst_excp_vld: got %0b want 0", lsu_excp_vld); end
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL rst_ots_cnt: got %0d want 0", ots_cnt); end
        nvec++; if (lsu_cmd_wstrb !== 4'b0000) begin nerr++; $display("FAIL rst_wstrb: got %b want 0000", lsu_cmd_wstrb); end
    endtask

    task automatic test_word_load();
        drive_op(1, 0, 2'd2, 0, 5'd7, 32'h1000, 32'd4, 32'h0);
        settle();
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL lw_op_rdy: got %0b want 1", op_rdy); end
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_vld !== 1'b1) begin nerr++; $display("FAIL lw_cmd_vld: got %0b want 1", lsu_cmd_vld); end
        nvec++; if (lsu_cmd_addr !== 32'h1004) begin nerr++; $display("FAIL lw_cmd_addr: got %h want 00001004", lsu_cmd_addr); end
        nvec++; if (lsu_cmd_write !== 1'b0) begin nerr++; $display("FAIL lw_cmd_write: got %0b want 0", lsu_cmd_write); end
        nvec++; if (lsu_cmd_wstrb !== 4'b0000) begin nerr++; $display("FAIL lw_wstrb: got %b want 0000", lsu_cmd_wstrb); end
        nvec++; if (ots_cnt !== 2'd1) begin nerr++; $display("FAIL lw_ots_cnt: got %0d want 1", ots_cnt); end
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'hDEADBEEF;
        settle();
        nvec++; if (gpr_wbck_vld !== 1'b1) begin nerr++; $display("FAIL lw_wbck_vld: got %0b want 1", gpr_wbck_vld); end
        nvec++; if (gpr_wbck_idx !== 5'd7) begin nerr++; $display("FAIL lw_wbck_idx: got %0d want 7", gpr_wbck_idx); end
        nvec++; if (gpr_wbck_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_wbck_wdata: got %h want deadbeef", gpr_wbck_wdata); end
        nvec++; if (lsu_rsp_rdy !== 1'b1) begin nerr++; $display("FAIL lw_rsp_rdy: got %0b want 1", lsu_rsp_rdy); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL lw_ots_after: got %0d want 0", ots_cnt); end
        nvec++; if (lsu_cmd_vld !== 1'b0) begin nerr++; $display("FAIL lw_cmd_clear: got %0b want 0", lsu_cmd_vld); end
    endtask

    task automatic test_byte_store_and_ext();
        drive_op(0, 1, 2'd0, 0, 5'd0, 32'h2000, 32'd3, 32'h000000A5);
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_addr !== 32'h2003) begin nerr++; $display("FAIL sb_addr: got %h want 00002003", lsu_cmd_addr); end
        nvec++; if (lsu_cmd_wdata !== 32'hA5A5A5A5) begin nerr++; $display("FAIL sb_wdata: got %h want a5a5a5a5", lsu_cmd_wdata); end
        nvec++; if (lsu_cmd_wstrb !== 4'b1000) begin nerr++; $display("FAIL sb_wstrb: got %b want 1000", lsu_cmd_wstrb); end
        nvec++; if (lsu_cmd_write !== 1'b1) begin nerr++; $display("FAIL sb_write: got %0b want 1", lsu_cmd_write); end
        lsu_rsp_vld = 1; lsu_rsp_err = 0; gpr_wbck_rdy = 0;
        settle();
        nvec++; if (lsu_rsp_rdy !== 1'b1) begin nerr++; $display("FAIL sb_rsp_rdy: got %0b want 1", lsu_rsp_rdy); end
        nvec++; if (gpr_wbck_vld !== 1'b0) begin nerr++; $display("FAIL sb_no_wbck: got %0b want 0", gpr_wbck_vld); end
        tick();
        lsu_rsp_vld = 0; gpr_wbck_rdy = 1;
        // signed byte load from lane 3
        drive_op(1, 0, 2'd0, 0, 5'd3, 32'h2000, 32'd3, 32'h0);
        tick();
        op_vld = 0;
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h80000000;
        settle();
        nvec++; if (gpr_wbck_wdata !== 32'hFFFFFF80) begin nerr++; $display("FAIL lb_wdata: got %h want ffffff80", gpr_wbck_wdata); end
        nvec++; if (gpr_wbck_idx !== 5'd3) begin nerr++; $display("FAIL lb_idx: got %0d want 3", gpr_wbck_idx); end
        tick();
        lsu_rsp_vld = 0;
        // unsigned byte load, same lane
        drive_op(1, 0, 2'd0, 1, 5'd4, 32'h2000, 32'd3, 32'h0);
        tick();
        op_vld = 0;
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h80000000;
        settle();
        nvec++; if (gpr_wbck_wdata !== 32'h00000080) begin nerr++; $display("FAIL lbu_wdata: got %h want 00000080", gpr_wbck_wdata); end
        tick();
        lsu_rsp_vld = 0;
        // signed half load from upper half
        drive_op(1, 0, 2'd1, 0, 5'd6, 32'h2000, 32'd2, 32'h0);
        tick();
        op_vld = 0;
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h87650000;
        settle();
        nvec++; if (gpr_wbck_wdata !== 32'hFFFF8765) begin nerr++; $display("FAIL lh_wdata: got %h want ffff8765", gpr_wbck_wdata); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL ext_ots_end: got %0d want 0", ots_cnt); end
    endtask

    task automatic test_outstanding();
        lsu_cmd_rdy = 1;
        drive_op(1, 0, 2'd2, 0, 5'd1, 32'h100, 32'd0, 32'h0);
        settle();
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL ots_rdy1: got %0b want 1", op_rdy); end
        tick();
        drive_op(1, 0, 2'd2, 0, 5'd2, 32'h100, 32'd4, 32'h0);
        settle();
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL ots_rdy2: got %0b want 1", op_rdy); end
        tick();
        drive_op(1, 0, 2'd2, 0, 5'd3, 32'h100, 32'd8, 32'h0);
        settle();
        nvec++; if (op_rdy !== 1'b0) begin nerr++; $display("FAIL ots_full_rdy: got %0b want 0", op_rdy); end
        nvec++; if (ots_cnt !== 2'd2) begin nerr++; $display("FAIL ots_full_cnt: got %0d want 2", ots_cnt); end
        tick();
        nvec++; if (op_rdy !== 1'b0) begin nerr++; $display("FAIL ots_stall_rdy: got %0b want 0", op_rdy); end
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h11;
        settle();
        nvec++; if (op_rdy !== 1'b0) begin nerr++; $display("FAIL ots_no_bypass: got %0b want 0", op_rdy); end
        nvec++; if (gpr_wbck_idx !== 5'd1) begin nerr++; $display("FAIL ots_wb1_idx: got %0d want 1", gpr_wbck_idx); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd1) begin nerr++; $display("FAIL ots_after_pop: got %0d want 1", ots_cnt); end
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL ots_rdy3: got %0b want 1", op_rdy); end
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_addr !== 32'h108) begin nerr++; $display("FAIL ots_cmd3_addr: got %h want 00000108", lsu_cmd_addr); end
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h22;
        settle();
        nvec++; if (gpr_wbck_idx !== 5'd2 || gpr_wbck_wdata !== 32'h22) begin nerr++; $display("FAIL ots_wb2: got idx %0d data %h want 2 00000022", gpr_wbck_idx, gpr_wbck_wdata); end
        tick();
        lsu_rsp_rdata = 32'h33;
        settle();
        nvec++; if (gpr_wbck_idx !== 5'd3 || gpr_wbck_wdata !== 32'h33) begin nerr++; $display("FAIL ots_wb3: got idx %0d data %h want 3 00000033", gpr_wbck_idx, gpr_wbck_wdata); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL ots_drained: got %0d want 0", ots_cnt); end
    endtask

    task automatic test_misalign();
        lsu_cmd_rdy = 1; lsu_excp_rdy = 1;
        drive_op(1, 0, 2'd2, 0, 5'd5, 32'h50, 32'd0, 32'h0);
        tick();
        drive_op(1, 0, 2'd1, 0, 5'd9, 32'h3000, 32'd1, 32'h0);
        settle();
        nvec++; if (lsu_excp_vld !== 1'b0) begin nerr++; $display("FAIL mis_wait_excp: got %0b want 0", lsu_excp_vld); end
        nvec++; if (op_rdy !== 1'b0) begin nerr++; $display("FAIL mis_wait_rdy: got %0b want 0", op_rdy); end
        tick();
        nvec++; if (lsu_cmd_vld !== 1'b0) begin nerr++; $display("FAIL mis_no_cmd: got %0b want 0", lsu_cmd_vld); end
        nvec++; if (lsu_excp_vld !== 1'b0) begin nerr++; $display("FAIL mis_wait_rsp: got %0b want 0", lsu_excp_vld); end
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h55;
        settle();
        nvec++; if (gpr_wbck_vld !== 1'b1 || gpr_wbck_idx !== 5'd5) begin nerr++; $display("FAIL mis_older_wb: got vld %0b idx %0d want 1 5", gpr_wbck_vld, gpr_wbck_idx); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (lsu_excp_vld !== 1'b1) begin nerr++; $display("FAIL mis_excp_vld: got %0b want 1", lsu_excp_vld); end
        nvec++; if (lsu_ld_addr_misalgn !== 1'b1 || lsu_st_addr_misalgn !== 1'b0) begin nerr++; $display("FAIL mis_flags: got ld %0b st %0b want 1 0", lsu_ld_addr_misalgn, lsu_st_addr_misalgn); end
        nvec++; if (lsu_bad_addr !== 32'h3001) begin nerr++; $display("FAIL mis_bad_addr: got %h want 00003001", lsu_bad_addr); end
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL mis_op_rdy: got %0b want 1", op_rdy); end
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_vld !== 1'b0 || ots_cnt !== 2'd0) begin nerr++; $display("FAIL mis_after: got cmd %0b cnt %0d want 0 0", lsu_cmd_vld, ots_cnt); end
    endtask

    task automatic test_store_err();
        lsu_cmd_rdy = 1;
        drive_op(0, 1, 2'd2, 0, 5'd0, 32'h4000, 32'd0, 32'h12345678);
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_wdata !== 32'h12345678 || lsu_cmd_wstrb !== 4'b1111) begin nerr++; $display("FAIL sw_cmd: got %h %b want 12345678 1111", lsu_cmd_wdata, lsu_cmd_wstrb); end
        tick();
        lsu_rsp_vld = 1; lsu_rsp_err = 1; lsu_excp_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            nvec++; if (lsu_rsp_rdy !== 1'b0) begin nerr++; $display("FAIL err_stall_rdy%0d: got %0b want 0", i, lsu_rsp_rdy); end
            nvec++; if (lsu_excp_vld !== 1'b1 || ots_cnt !== 2'd1) begin nerr++; $display("FAIL err_stall_hold%0d: got excp %0b cnt %0d want 1 1", i, lsu_excp_vld, ots_cnt); end
            tick();
        end
        lsu_excp_rdy = 1;
        settle();
        nvec++; if (lsu_rsp_rdy !== 1'b1) begin nerr++; $display("FAIL err_rsp_rdy: got %0b want 1", lsu_rsp_rdy); end
        nvec++; if (lsu_st_access_fault !== 1'b1 || lsu_ld_access_fault !== 1'b0) begin nerr++; $display("FAIL err_flags: got st %0b ld %0b want 1 0", lsu_st_access_fault, lsu_ld_access_fault); end
        nvec++; if (lsu_bad_addr !== 32'h4000) begin nerr++; $display("FAIL err_bad_addr: got %h want 00004000", lsu_bad_addr); end
        nvec++; if (gpr_wbck_vld !== 1'b0) begin nerr++; $display("FAIL err_no_wbck: got %0b want 0", gpr_wbck_vld); end
        tick();
        lsu_rsp_vld = 0; lsu_rsp_err = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL err_popped: got %0d want 0", ots_cnt); end
    endtask

    task automatic test_back_to_back();
        lsu_cmd_rdy = 0;
        drive_op(0, 1, 2'd1, 0, 5'd0, 32'h6000, 32'd2, 32'h0000BEEF);
        tick();
        drive_op(1, 0, 2'd2, 0, 5'd8, 32'h7000, 32'd0, 32'h0);
        settle();
        nvec++; if (op_rdy !== 1'b0) begin nerr++; $display("FAIL b2b_blocked: got %0b want 0", op_rdy); end
        tick();
        nvec++; if (lsu_cmd_vld !== 1'b1 || lsu_cmd_addr !== 32'h6002) begin nerr++; $display("FAIL b2b_hold_addr: got %0b %h want 1 00006002", lsu_cmd_vld, lsu_cmd_addr); end
        nvec++; if (lsu_cmd_wdata !== 32'hBEEFBEEF || lsu_cmd_wstrb !== 4'b1100) begin nerr++; $display("FAIL b2b_hold_data: got %h %b want beefbeef 1100", lsu_cmd_wdata, lsu_cmd_wstrb); end
        lsu_cmd_rdy = 1;
        settle();
        nvec++; if (op_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_rdy: got %0b want 1", op_rdy); end
        tick();
        op_vld = 0;
        settle();
        nvec++; if (lsu_cmd_vld !== 1'b1 || lsu_cmd_addr !== 32'h7000 || lsu_cmd_wstrb !== 4'b0000) begin nerr++; $display("FAIL b2b_second: got %0b %h %b want 1 00007000 0000", lsu_cmd_vld, lsu_cmd_addr, lsu_cmd_wstrb); end
        nvec++; if (ots_cnt !== 2'd2) begin nerr++; $display("FAIL b2b_cnt: got %0d want 2", ots_cnt); end
        tick();
        nvec++; if (lsu_cmd_vld !== 1'b0) begin nerr++; $display("FAIL b2b_cmd_done: got %0b want 0", lsu_cmd_vld); end
        lsu_rsp_vld = 1; lsu_rsp_rdata = 32'h0;
        tick();
        lsu_rsp_rdata = 32'hCAFE0001;
        settle();
        nvec++; if (gpr_wbck_idx !== 5'd8 || gpr_wbck_wdata !== 32'hCAFE0001) begin nerr++; $display("FAIL b2b_wb: got %0d %h want 8 cafe0001", gpr_wbck_idx, gpr_wbck_wdata); end
        tick();
        lsu_rsp_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd0) begin nerr++; $display("FAIL b2b_drained: got %0d want 0", ots_cnt); end
    endtask

    task automatic test_reset_mid();
        lsu_cmd_rdy = 1;
        drive_op(1, 0, 2'd2, 0, 5'd1, 32'h800, 32'd0, 32'h0);
        tick();
        drive_op(1, 0, 2'd2, 0, 5'd2, 32'h800, 32'd4, 32'h0);
        tick();
        op_vld = 0;
        settle();
        nvec++; if (ots_cnt !== 2'd2 || lsu_cmd_vld !== 1'b1) begin nerr++; $display("FAIL rmid_pre: got cnt %0d cmd %0b want 2 1", ots_cnt, lsu_cmd_vld); end
        reset = 1;
        tick();
        reset = 0;
        settle();
        nvec++; if (lsu_cmd_vld !== 1'b0 || ots_cnt !== 2'd0) begin nerr++; $display("FAIL rmid_state: got cmd %0b cnt %0d want 0 0", lsu_cmd_vld, ots_cnt); end
        nvec++; if (lsu_rsp_rdy !== 1'b0 || gpr_wbck_vld !== 1'b0 || lsu_excp_vld !== 1'b0) begin nerr++; $display("FAIL rmid_valids: got rsp_rdy %0b wbck %0b excp %0b want 0 0 0", lsu_rsp_rdy, gpr_wbck_vld, lsu_excp_vld); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store_and_ext();
        test_outstanding();
        test_misalign();
        test_store_err();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
